// File: rtl/if_id_latch.sv
// IF/ID pipeline register: latches instruction and PC+2, decodes the immediate class, and tracks a sticky HALT.
// Latency: one cycle from if_* to id_*. Stall holds the register, flush loads a NOP bubble, and a latched HALT freezes the stage.
module if_id_latch #(
    parameter int unsigned       DATA_W    = 16,
    parameter logic [DATA_W-1:0] NOP_INSTR = 16'h0800,
    parameter logic [DATA_W-1:0] RESET_PC  = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] if_instr,
    input  logic [DATA_W-1:0] if_pc_inc,
    input  logic              if_valid,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] id_instr,
    output logic [DATA_W-1:0] id_pc_inc,
    output logic              id_valid,
    output logic [10:0]       in_11_bit,
    output logic [7:0]        in_8_bit,
    output logic [4:0]        in_5_bit,
    output logic              ext_type,
    output logic [1:0]        length_in,
    output logic              halted
);

    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] pc_inc_q, pc_inc_d;
    logic              valid_q, valid_d;
    logic              ext_q, ext_d;
    logic [1:0]        len_q, len_d;
    logic              halted_q, halted_d;

    logic [4:0]        opc;
    logic              dec_ext;
    logic [1:0]        dec_len;

    assign opc = if_instr[DATA_W-1 -: 5];

    // Immediate class of the incoming instruction: {sign-extend, field length}
    always_comb begin
        dec_ext = 1'b0;
        dec_len = 2'b00;
        casez (opc)
            5'b0100?, 5'b10000, 5'b10001, 5'b10011: begin
                dec_ext = 1'b1;
                dec_len = 2'b00;
            end
            5'b011??, 5'b11000, 5'b00101, 5'b00111: begin
                dec_ext = 1'b1;
                dec_len = 2'b01;
            end
            5'b10010: begin
                dec_ext = 1'b0;
                dec_len = 2'b01;
            end
            5'b00100, 5'b00110: begin
                dec_ext = 1'b1;
                dec_len = 2'b10;
            end
            default: begin
                dec_ext = 1'b0;
                dec_len = 2'b00;
            end
        endcase
    end

    always_comb begin
        instr_d  = instr_q;
        pc_inc_d = pc_inc_q;
        valid_d  = valid_q;
        ext_d    = ext_q;
        len_d    = len_q;
        halted_d = halted_q;
        if (flush) begin
            instr_d  = NOP_INSTR;
            valid_d  = 1'b0;
            ext_d    = 1'b0;
            len_d    = 2'b00;
            halted_d = 1'b0;
        end else if (halted_q) begin
            // HALT is presented valid for exactly one cycle, then the stage freezes
            valid_d = 1'b0;
        end else if (!stall) begin
            pc_inc_d = if_pc_inc;
            valid_d  = if_valid;
            if (if_valid) begin
                instr_d  = if_instr;
                ext_d    = dec_ext;
                len_d    = dec_len;
                halted_d = (opc == 5'b00000);
            end else begin
                instr_d = NOP_INSTR;
                ext_d   = 1'b0;
                len_d   = 2'b00;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q  <= NOP_INSTR;
            pc_inc_q <= RESET_PC;
            valid_q  <= 1'b0;
            ext_q    <= 1'b0;
            len_q    <= 2'b00;
            halted_q <= 1'b0;
        end else begin
            instr_q  <= instr_d;
            pc_inc_q <= pc_inc_d;
            valid_q  <= valid_d;
            ext_q    <= ext_d;
            len_q    <= len_d;
            halted_q <= halted_d;
        end
    end

    assign id_instr  = instr_q;
    assign id_pc_inc = pc_inc_q;
    assign id_valid  = valid_q;
    assign ext_type  = ext_q;
    assign length_in = len_q;
    assign halted    = halted_q;
    assign in_11_bit = instr_q[10:0];
    assign in_8_bit  = instr_q[7:0];
    assign in_5_bit  = instr_q[4:0];

endmodule

// File: tb/tb_if_id_latch.sv
// Bench for if_id_latch: per-scenario tables of stimulus and hand-written expected outputs, checked through a queue.
module tb_if_id_latch;

    typedef struct {
        logic        rst, flush, stall, vld;
        logic [15:0] instr, pc;
    } stim_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic        vld;
        logic        ext;
        logic [1:0]  len;
        logic        hlt;
        logic [10:0] f11;
        logic [7:0]  f8;
        logic [4:0]  f5;
    } out_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] if_instr = 16'h0000;
    logic [15:0] if_pc_inc = 16'h0000;
    logic        if_valid = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] id_instr, id_pc_inc;
    logic        id_valid, ext_type, halted;
    logic [10:0] in_11_bit;
    logic [7:0]  in_8_bit;
    logic [4:0]  in_5_bit;
    logic [1:0]  length_in;

    int   total = 0;
    int   bad   = 0;
    out_t sb[$];

    if_id_latch dut (
        .clk(clk), .rst(rst), .if_instr(if_instr), .if_pc_inc(if_pc_inc),
        .if_valid(if_valid), .stall(stall), .flush(flush),
        .id_instr(id_instr), .id_pc_inc(id_pc_inc), .id_valid(id_valid),
        .in_11_bit(in_11_bit), .in_8_bit(in_8_bit), .in_5_bit(in_5_bit),
        .ext_type(ext_type), .length_in(length_in), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic stim_t st(logic r, logic f, logic s, logic v, logic [15:0] i, logic [15:0] p);
        stim_t x;
        x.rst = r; x.flush = f; x.stall = s; x.vld = v; x.instr = i; x.pc = p;
        return x;
    endfunction

    function automatic out_t ex(logic [15:0] i, logic [15:0] p, logic v, logic e, logic [1:0] l, logic h);
        out_t x;
        x.instr = i; x.pc = p; x.vld = v; x.ext = e; x.len = l; x.hlt = h;
        x.f11 = i[10:0]; x.f8 = i[7:0]; x.f5 = i[4:0];
        return x;
    endfunction

    function automatic out_t observe();
        out_t x;
        x.instr = id_instr; x.pc = id_pc_inc; x.vld = id_valid; x.ext = ext_type;
        x.len = length_in; x.hlt = halted; x.f11 = in_11_bit; x.f8 = in_8_bit; x.f5 = in_5_bit;
        return x;
    endfunction

    task automatic drive(input stim_t s);
        @(negedge clk);
        rst = s.rst; flush = s.flush; stall = s.stall;
        if_valid = s.vld; if_instr = s.instr; if_pc_inc = s.pc;
    endtask

    task automatic test_reset();
        stim_t s[$]; out_t e[$]; out_t got, want;
        s.push_back(st(1,0,0,1,16'h4005,16'h0002)); e.push_back(ex(16'h0800,16'h0000,0,0,2'b00,0));
        s.push_back(st(1,0,0,1,16'h4005,16'h0004)); e.push_back(ex(16'h0800,16'h0000,0,0,2'b00,0));
        foreach (s[i]) begin
            drive(s[i]); sb.push_back(e[i]);
            @(posedge clk); #1;
            got = observe(); want = sb.pop_front(); total++;
            if (got !== want) begin
                bad++;
                $display("FAIL reset[%0d] got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_load_decode();
        stim_t s[$]; out_t e[$]; out_t got, want;
        s.push_back(st(0,0,0,1,16'h4005,16'h0010)); e.push_back(ex(16'h4005,16'h0010,1,1,2'b00,0));
        s.push_back(st(0,0,0,1,16'h6280,16'h0012)); e.push_back(ex(16'h6280,16'h0012,1,1,2'b01,0));
        s.push_back(st(0,0,0,1,16'h2401,16'h0014)); e.push_back(ex(16'h2401,16'h0014,1,1,2'b10,0));
        s.push_back(st(0,0,0,1,16'h5000,16'h0016)); e.push_back(ex(16'h5000,16'h0016,1,0,2'b00,0));
        s.push_back(st(0,0,0,1,16'h9000,16'h0018)); e.push_back(ex(16'h9000,16'h0018,1,0,2'b01,0));
        s.push_back(st(0,0,0,1,16'hC0FF,16'h001A)); e.push_back(ex(16'hC0FF,16'h001A,1,1,2'b01,0));
        s.push_back(st(0,0,0,1,16'h3000,16'h001C)); e.push_back(ex(16'h3000,16'h001C,1,1,2'b10,0));
        s.push_back(st(0,0,0,1,16'h8800,16'h001E)); e.push_back(ex(16'h8800,16'h001E,1,1,2'b00,0));
        s.push_back(st(0,0,0,1,16'hA000,16'h0020)); e.push_back(ex(16'hA000,16'h0020,1,0,2'b00,0));
        s.push_back(st(0,0,0,1,16'h3800,16'h0022)); e.push_back(ex(16'h3800,16'h0022,1,1,2'b01,0));
        s.push_back(st(0,0,0,1,16'hE000,16'h0024)); e.push_back(ex(16'hE000,16'h0024,1,0,2'b00,0));
        s.push_back(st(0,0,0,1,16'h2800,16'h0026)); e.push_back(ex(16'h2800,16'h0026,1,1,2'b01,0));
        s.push_back(st(0,0,0,1,16'h9800,16'h0028)); e.push_back(ex(16'h9800,16'h0028,1,1,2'b00,0));
        s.push_back(st(0,0,0,1,16'h0800,16'h002A)); e.push_back(ex(16'h0800,16'h002A,1,0,2'b00,0));
        foreach (s[i]) begin
            drive(s[i]); sb.push_back(e[i]);
            @(posedge clk); #1;
            got = observe(); want = sb.pop_front(); total++;
            if (got !== want) begin
                bad++;
                $display("FAIL load_decode[%0d] got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_stall();
        stim_t s[$]; out_t e[$]; out_t got, want;
        s.push_back(st(0,0,0,1,16'h4005,16'h0030)); e.push_back(ex(16'h4005,16'h0030,1,1,2'b00,0));
        for (int k = 0; k < 3; k++) begin
            s.push_back(st(0,0,1,1,16'h9000,16'h0032)); e.push_back(ex(16'h4005,16'h0030,1,1,2'b00,0));
        end
        s.push_back(st(0,0,0,1,16'h9000,16'h0032)); e.push_back(ex(16'h9000,16'h0032,1,0,2'b01,0));
        foreach (s[i]) begin
            drive(s[i]); sb.push_back(e[i]);
            @(posedge clk); #1;
            got = observe(); want = sb.pop_front(); total++;
            if (got !== want) begin
                bad++;
                $display("FAIL stall[%0d] got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_flush_vs_stall();
        stim_t s[$]; out_t e[$]; out_t got, want;
        s.push_back(st(0,0,0,1,16'h6280,16'h0040)); e.push_back(ex(16'h6280,16'h0040,1,1,2'b01,0));
        s.push_back(st(0,1,1,1,16'h4005,16'h0042)); e.push_back(ex(16'h0800,16'h0040,0,0,2'b00,0));
        s.push_back(st(0,0,0,1,16'h4005,16'h0044)); e.push_back(ex(16'h4005,16'h0044,1,1,2'b00,0));
        foreach (s[i]) begin
            drive(s[i]); sb.push_back(e[i]);
            @(posedge clk); #1;
            got = observe(); want = sb.pop_front(); total++;
            if (got !== want) begin
                bad++;
                $display("FAIL flush_vs_stall[%0d] got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_halt();
        stim_t s[$]; out_t e[$]; out_t got, want;
        s.push_back(st(0,0,0,1,16'h0000,16'h0050)); e.push_back(ex(16'h0000,16'h0050,1,0,2'b00,1));
        s.push_back(st(0,0,0,1,16'h4005,16'h0052)); e.push_back(ex(16'h0000,16'h0050,0,0,2'b00,1));
        s.push_back(st(0,0,0,1,16'h4005,16'h0054)); e.push_back(ex(16'h0000,16'h0050,0,0,2'b00,1));
        s.push_back(st(0,0,1,1,16'h4005,16'h0056)); e.push_back(ex(16'h0000,16'h0050,0,0,2'b00,1));
        s.push_back(st(0,1,0,1,16'h4005,16'h0058)); e.push_back(ex(16'h0800,16'h0050,0,0,2'b00,0));
        s.push_back(st(0,0,0,1,16'h4005,16'h005A)); e.push_back(ex(16'h4005,16'h005A,1,1,2'b00,0));
        s.push_back(st(0,0,0,1,16'h0000,16'h005C)); e.push_back(ex(16'h0000,16'h005C,1,0,2'b00,1));
        s.push_back(st(1,0,0,1,16'h4005,16'h005E)); e.push_back(ex(16'h0800,16'h0000,0,0,2'b00,0));
        foreach (s[i]) begin
            drive(s[i]); sb.push_back(e[i]);
            @(posedge clk); #1;
            got = observe(); want = sb.pop_front(); total++;
            if (got !== want) begin
                bad++;
                $display("FAIL halt[%0d] got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_invalid();
        stim_t s[$]; out_t e[$]; out_t got, want;
        s.push_back(st(0,0,0,1,16'h6280,16'h0060)); e.push_back(ex(16'h6280,16'h0060,1,1,2'b01,0));
        s.push_back(st(0,0,0,0,16'h2401,16'h0062)); e.push_back(ex(16'h0800,16'h0062,0,0,2'b00,0));
        s.push_back(st(0,0,0,0,16'h0000,16'h0064)); e.push_back(ex(16'h0800,16'h0064,0,0,2'b00,0));
        s.push_back(st(0,0,1,1,16'h2401,16'h0066)); e.push_back(ex(16'h0800,16'h0064,0,0,2'b00,0));
        s.push_back(st(0,0,0,1,16'h2401,16'h0066)); e.push_back(ex(16'h2401,16'h0066,1,1,2'b10,0));
        foreach (s[i]) begin
            drive(s[i]); sb.push_back(e[i]);
            @(posedge clk); #1;
            got = observe(); want = sb.pop_front(); total++;
            if (got !== want) begin
                bad++;
                $display("FAIL invalid[%0d] got=%h want=%h", i, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_decode();
        test_stall();
        test_flush_vs_stall();
        test_halt();
        test_invalid();
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
